pci_rr_arbiter: RTL and testbench
=================================

PCI_RR_ARBITER -- requirements
Module: pci_rr_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 8: number of PCI masters; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 16: clocks a granted master has to assert FRAME# before the grant is revoked; legal range 2..255.
REQ-003 clk  input  1  PCI clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_n  input  N_MASTERS  per-master request, active-low (REQ#).
REQ-006 frame_n  input  1  bus FRAME#, active-low.
REQ-007 irdy_n  input  1  bus IRDY#, active-low.
REQ-008 gnt_n  output  N_MASTERS  per-master grant, active-low (GNT#), registered.
REQ-009 owner  output  clog2(N_MASTERS)  index of the currently or last granted master, registered.
REQ-010 owner_vld  output  1  high exactly when one gnt_n bit is low.

Function
REQ-011 gnt_n SHALL have at most one bit low in any cycle.
REQ-012 Bus idle SHALL be defined as frame_n high and irdy_n high in the same sampled cycle.
REQ-013 The FSM SHALL have three states: IDLE, GRANT, BUSY.
REQ-014 IDLE: all gnt_n high; if any req_n bit is low and the bus is idle, select a winner and enter GRANT, with gnt_n[winner] low from the next rising edge (1-clock request-to-grant latency).
REQ-015 Winner selection SHALL be round-robin: search upward from ptr+1, wrapping at N_MASTERS-1 to 0; the first low req_n bit wins; ptr is then set to the winner.
REQ-016 GRANT: if frame_n is sampled low, enter BUSY with the grant held.
REQ-017 GRANT: if req_n[owner] is sampled high before frame_n goes low, drive all gnt_n high and return to IDLE.
REQ-018 BUSY: hold gnt_n[owner] low while req_n[owner] is low; when req_n[owner] goes high, drive all gnt_n high the next cycle and remain in BUSY until the bus is idle, then go to IDLE.
REQ-019 Any transition from a granted state to IDLE SHALL leave at least one full clock with all gnt_n high before the next grant.
REQ-020 Requests from non-owners during GRANT or BUSY SHALL not change gnt_n; they are arbitrated on return to IDLE.
REQ-021 A single requester SHALL be re-granted repeatedly, with one idle clock between grants.
REQ-022 owner SHALL update on the same edge that asserts a new grant and SHALL hold its value otherwise.

Reset
REQ-023 While rst is low: gnt_n all ones, owner 0, owner_vld 0, FSM in IDLE, ptr = N_MASTERS-1 (master 0 has first priority), timeout counter 0.
REQ-024 Reset asserted mid-grant or mid-transaction SHALL drop all grants immediately (asynchronous), with no dependence on clk.
REQ-025 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN: when defined, an 8-bit counter clears on entry to GRANT and increments each clock in GRANT.
REQ-027 Timeout expiry: when the counter reaches TIMEOUT-1 with frame_n still high, all gnt_n go high and the FSM returns to IDLE; ptr keeps the revoked master, so it has lowest priority next round.
REQ-028 When ARB_TIMEOUT_EN is not defined, no counter is synthesised, TIMEOUT is ignored, and GRANT waits indefinitely for frame_n or request withdrawal.

Verification
REQ-029 Reset then req_n=8'hFE, bus idle -> gnt_n=8'hFE one clock later, owner=0, owner_vld=1.
REQ-030 req_n=8'h00 held, each master runs a 3-clock FRAME# cycle then releases REQ# -> grant order 0,1,2,...,7,0, with at least one all-ones gnt_n clock between grants.
REQ-031 Master 3 granted, frame_n low, req_n[3] released while frame_n still low for 2 clocks -> gnt_n=8'hFF immediately, next grant only after frame_n=irdy_n=1.
REQ-032 Master 5 granted, req_n[5] withdrawn before FRAME# -> gnt_n=8'hFF next clock, FSM in IDLE, master 6 (requesting) granted after the idle clock.
REQ-033 With ARB_TIMEOUT_EN defined and TIMEOUT=16, master 2 granted and frame_n kept high -> grant revoked after 16 clocks, master 3 requesting is granted next; without the macro, grant still held after 100 clocks.
REQ-034 rst pulsed low while master 4 is in BUSY -> gnt_n=8'hFF asynchronously; after release, master 0 wins if requesting.

Source files
------------

// File: rtl/pci_rr_arbiter_if.sv
// PCI arbiter bus bundle: REQ#/GNT# per master plus shared FRAME#/IRDY# and owner status.
// master modport is the arbiter side; slave modport is the masters/bus side.
interface pci_rr_arbiter_if #(
  parameter int N_MASTERS = 8
);
  localparam int W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] req_n;
  logic                 frame_n;
  logic                 irdy_n;
  logic [N_MASTERS-1:0] gnt_n;
  logic [W-1:0]         owner;
  logic                 owner_vld;

  modport master (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, owner_vld
  );

  modport slave (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, owner_vld
  );
endinterface

// File: rtl/pci_rr_arbiter.sv
// Round-robin PCI bus arbiter (IDLE/GRANT/BUSY), registered GNT#, 1-clock request-to-grant latency.
// Optional grant timeout when ARB_TIMEOUT_EN is defined; without it GRANT waits for FRAME# or REQ# withdrawal.
module pci_rr_arbiter #(
  parameter int N_MASTERS = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  pci_rr_arbiter_if.master    bus
);
  localparam int W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [N_MASTERS-1:0] ALL1 = '1;

  if (N_MASTERS < 2 || N_MASTERS > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
    $error("pci_rr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [W-1:0]         owner_q, owner_d;
  logic [W-1:0]         ptr_q, ptr_d;
  logic                 vld_q, vld_d;
  logic                 rel_q;
  logic                 win_found;
  logic [W-1:0]         win_idx;
  logic [W:0]           rr_sum;
  logic                 bus_idle;
  logic                 own_req;
  logic                 tmo_hit;

  assign bus_idle = bus.frame_n & bus.irdy_n;
  assign own_req  = ~bus.req_n[owner_q];

  // Round-robin search starting just above the last winner, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      rr_sum = {1'b0, ptr_q} + (W+1)'(i);
      if (rr_sum >= (W+1)'(N_MASTERS)) rr_sum = rr_sum - (W+1)'(N_MASTERS);
      if (!win_found && !bus.req_n[rr_sum[W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d = ALL1;
        if (rel_q && win_found && bus_idle) begin
          state_d          = GRANT;
          gnt_d[win_idx]   = 1'b0;
          owner_d          = win_idx;
          ptr_d            = win_idx;
        end
      end
      GRANT: begin
        if (!bus.frame_n) begin
          state_d = BUSY;
        end else if (!own_req || tmo_hit) begin
          state_d = IDLE;
          gnt_d   = ALL1;
        end
      end
      BUSY: begin
        // Once released, the grant stays off until the transaction drains.
        if (!own_req || (&gnt_q)) begin
          gnt_d = ALL1;
          if (bus_idle) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = ALL1;
      end
    endcase
    vld_d = ~(&gnt_d);
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == GRANT) && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == GRANT) cnt_d = '0;
    else if (state_q == GRANT)               cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // rel_q blocks a grant on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= ALL1;
      owner_q <= '0;
      ptr_q   <= W'(N_MASTERS - 1);
      vld_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      rel_q   <= 1'b1;
    end
  end

  assign bus.gnt_n     = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = vld_q;
endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for pci_rr_arbiter (8 masters).
module tb_pci_rr_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pci_rr_arbiter_if #(.N_MASTERS(8)) ifc ();

  pci_rr_arbiter #(.N_MASTERS(8), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       frame;
    logic       irdy;
    logic [7:0] gnt;
    logic [2:0] own;
    logic       vld;
  } vec_t;

  vec_t tbl [22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] req, input logic frame, input logic irdy);
    ifc.req_n   = req;
    ifc.frame_n = frame;
    ifc.irdy_n  = irdy;
  endtask

  task automatic do_reset();
    drive(8'hFF, 1'b1, 1'b1);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      tick();
      if (ifc.owner_vld === 1'b1) got = 1'b1;
    end
    chk({name, "_granted"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    tbl[0]  = '{8'hFE, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[1]  = '{8'hFE, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b1};
    tbl[2]  = '{8'hFE, 1'b0, 1'b1, 8'hFE, 3'd0, 1'b1};
    tbl[3]  = '{8'hFC, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1};
    tbl[4]  = '{8'hFD, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0};
    tbl[5]  = '{8'hFD, 1'b1, 1'b0, 8'hFF, 3'd0, 1'b0};
    tbl[6]  = '{8'hFD, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[7]  = '{8'hFD, 1'b1, 1'b1, 8'hFD, 3'd1, 1'b1};
    tbl[8]  = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd1, 1'b0};
    tbl[9]  = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd1, 1'b0};
    tbl[10] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 3'd7, 1'b1};
    tbl[11] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 3'd7, 1'b1};
    tbl[12] = '{8'h7E, 1'b0, 1'b1, 8'h7F, 3'd7, 1'b1};
    tbl[13] = '{8'h7E, 1'b0, 1'b0, 8'h7F, 3'd7, 1'b1};
    tbl[14] = '{8'hFE, 1'b0, 1'b0, 8'hFF, 3'd7, 1'b0};
    tbl[15] = '{8'hFE, 1'b1, 1'b1, 8'hFF, 3'd7, 1'b0};
    tbl[16] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b1};
    tbl[17] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[18] = '{8'hF7, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[19] = '{8'hF7, 1'b1, 1'b0, 8'hFF, 3'd0, 1'b0};
    tbl[20] = '{8'hF7, 1'b1, 1'b1, 8'hF7, 3'd3, 1'b1};
    tbl[21] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'd3, 1'b0};

    // Reset state
    rst = 1'b0;
    drive(8'hFE, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_gnt", {24'd0, ifc.gnt_n}, 32'hFF);
    chk("rst_owner", {29'd0, ifc.owner}, 32'd0);
    chk("rst_vld", {31'd0, ifc.owner_vld}, 32'd0);
    rst = 1'b1;

    for (int r = 0; r < 22; r++) begin
      drive(tbl[r].req, tbl[r].frame, tbl[r].irdy);
      tick();
      chk($sformatf("v%0d_gnt", r), {24'd0, ifc.gnt_n}, {24'd0, tbl[r].gnt});
      chk($sformatf("v%0d_owner", r), {29'd0, ifc.owner}, {29'd0, tbl[r].own});
      chk($sformatf("v%0d_vld", r), {31'd0, ifc.owner_vld}, {31'd0, tbl[r].vld});
    end

    // Full rotation with every master requesting
    do_reset();
    drive(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_g;
      logic [7:0] rq;
      exp_g = ~(8'd1 << (k % 8));
      wait_grant($sformatf("rot%0d", k));
      chk($sformatf("rot%0d_owner", k), {29'd0, ifc.owner}, 32'(k % 8));
      chk($sformatf("rot%0d_gnt", k), {24'd0, ifc.gnt_n}, {24'd0, exp_g});
      ifc.frame_n = 1'b0;
      ifc.irdy_n  = 1'b0;
      tick();
      tick();
      tick();
      chk($sformatf("rot%0d_held", k), {24'd0, ifc.gnt_n}, {24'd0, exp_g});
      rq = 8'h00;
      rq[k % 8] = 1'b1;
      drive(rq, 1'b1, 1'b1);
      tick();
      chk($sformatf("rot%0d_gap", k), {24'd0, ifc.gnt_n}, 32'hFF);
      ifc.req_n = 8'h00;
    end

    // Owner releases REQ# mid-transaction
    do_reset();
    drive(8'hE7, 1'b1, 1'b1);
    wait_grant("rel3");
    chk("rel3_owner", {29'd0, ifc.owner}, 32'd3);
    drive(8'hE7, 1'b0, 1'b0);
    tick();
    ifc.req_n = 8'hEF;
    tick();
    chk("rel3_drop", {24'd0, ifc.gnt_n}, 32'hFF);
    tick();
    chk("rel3_busy", {24'd0, ifc.gnt_n}, 32'hFF);
    drive(8'hEF, 1'b1, 1'b1);
    tick();
    chk("rel3_idle", {24'd0, ifc.gnt_n}, 32'hFF);
    tick();
    chk("rel3_next_gnt", {24'd0, ifc.gnt_n}, 32'hEF);
    chk("rel3_next_owner", {29'd0, ifc.owner}, 32'd4);

    // Withdrawal before FRAME#
    ifc.req_n = 8'h9F;
    tick();
    chk("wd4_drop", {24'd0, ifc.gnt_n}, 32'hFF);
    tick();
    chk("wd5_gnt", {24'd0, ifc.gnt_n}, 32'hDF);
    ifc.req_n = 8'hBF;
    tick();
    chk("wd5_drop", {24'd0, ifc.gnt_n}, 32'hFF);
    chk("wd5_vld", {31'd0, ifc.owner_vld}, 32'd0);
    chk("wd5_owner_hold", {29'd0, ifc.owner}, 32'd5);
    tick();
    chk("wd6_gnt", {24'd0, ifc.gnt_n}, 32'hBF);
    chk("wd6_owner", {29'd0, ifc.owner}, 32'd6);

    // Grant with FRAME# never asserted
    do_reset();
    drive(8'hF3, 1'b1, 1'b1);
    wait_grant("tmo");
    chk("tmo_owner", {29'd0, ifc.owner}, 32'd2);
`ifdef ARB_TIMEOUT_EN
    for (int n = 0; n < 15; n++) tick();
    chk("tmo_held15", {24'd0, ifc.gnt_n}, 32'hFB);
    tick();
    chk("tmo_revoked", {24'd0, ifc.gnt_n}, 32'hFF);
    tick();
    chk("tmo_next_gnt", {24'd0, ifc.gnt_n}, 32'hF7);
    chk("tmo_next_owner", {29'd0, ifc.owner}, 32'd3);
`else
    for (int n = 0; n < 100; n++) tick();
    chk("notmo_held100", {24'd0, ifc.gnt_n}, 32'hFB);
    chk("notmo_owner", {29'd0, ifc.owner}, 32'd2);
`endif

    // Asynchronous reset during BUSY
    do_reset();
    drive(8'hEF, 1'b1, 1'b1);
    wait_grant("ar4");
    chk("ar4_owner", {29'd0, ifc.owner}, 32'd4);
    drive(8'hEF, 1'b0, 1'b0);
    tick();
    chk("ar4_busy", {24'd0, ifc.gnt_n}, 32'hEF);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_async_gnt", {24'd0, ifc.gnt_n}, 32'hFF);
    chk("ar_async_vld", {31'd0, ifc.owner_vld}, 32'd0);
    chk("ar_async_owner", {29'd0, ifc.owner}, 32'd0);
    drive(8'hEE, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_first_edge", {24'd0, ifc.gnt_n}, 32'hFF);
    tick();
    chk("ar_m0_gnt", {24'd0, ifc.gnt_n}, 32'hFE);
    chk("ar_m0_owner", {29'd0, ifc.owner}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
